// File: rtl/mips_mc_ctrl_pkg.sv
// Shared opcodes, state and control-field encodings for the multi-cycle MIPS controller.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam int unsigned WDOG_W = 16;

  typedef enum logic [3:0] {
    ST_FETCH, ST_DECODE, ST_MEM_ADDR, ST_MEM_RD, ST_MEM_WB, ST_MEM_WR,
    ST_R_EXEC, ST_R_WB, ST_I_EXEC, ST_I_WB, ST_BRANCH, ST_JUMP, ST_TRAP
  } ctrl_state_t;

  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_FUNCT, ALU_RSVD} alu_op_t;
  typedef enum logic [1:0] {SRCB_RT, SRCB_FOUR, SRCB_IMM, SRCB_IMM_SH2} alu_src_b_t;
  typedef enum logic [1:0] {PC_ALU, PC_ALUOUT, PC_JUMP, PC_RSVD} pc_src_t;
  typedef enum logic [1:0] {CAUSE_NONE, CAUSE_ILLEGAL, CAUSE_FETCH_TO, CAUSE_DATA_TO} trap_cause_t;

  // Instruction-class dispatch out of DECODE; unknown opcodes trap.
  function automatic ctrl_state_t decode_next(input logic [5:0] op);
    ctrl_state_t s;
    case (op)
      OP_LW, OP_SW: s = ST_MEM_ADDR;
      OP_RTYPE:     s = ST_R_EXEC;
      OP_BEQ:       s = ST_BRANCH;
      OP_ADDI:      s = ST_I_EXEC;
      OP_J:         s = ST_JUMP;
      default:      s = ST_TRAP;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// Controller <-> datapath/memory signal bundle; master is the control unit.
interface mips_mc_ctrl_if;

  logic [5:0]              opcode;
  logic [5:0]              funct;
  logic                    alu_zero;
  logic                    mem_ready;
  logic                    mem_req;
  logic                    mem_write;
  logic                    iord;
  logic                    ir_write;
  logic                    pc_write;
  logic                    pc_write_cond;
  mips_pkg::pc_src_t       pc_src;
  logic                    reg_write_en;
  logic                    reg_dst;
  logic                    mem_to_reg;
  logic                    alu_src_a;
  mips_pkg::alu_src_b_t    alu_src_b;
  mips_pkg::alu_op_t       alu_op;
  logic                    trap;
  mips_pkg::trap_cause_t   trap_cause;

  modport master (
    input  opcode, funct, alu_zero, mem_ready,
    output mem_req, mem_write, iord, ir_write, pc_write, pc_write_cond, pc_src,
           reg_write_en, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
           trap, trap_cause
  );

  modport slave (
    output opcode, funct, alu_zero, mem_ready,
    input  mem_req, mem_write, iord, ir_write, pc_write, pc_write_cond, pc_src,
           reg_write_en, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
           trap, trap_cause
  );

endinterface

// File: rtl/mips_mc_ctrl_watchdog.sv
// Memory-wait watchdog: flags the TIMEOUT_CYCLES-th consecutive cycle of req without ready.
module mips_mem_watchdog
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic i_ready,
  output logic o_timeout_c
);

  logic [WDOG_W-1:0] r_cnt;
  logic              w_wait;

  assign w_wait      = i_req & ~i_ready;
  assign o_timeout_c = w_wait && (r_cnt == WDOG_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_wait) begin
      r_cnt <= r_cnt + WDOG_W'(1);
    end else begin
      r_cnt <= '0;
    end
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM with memory watchdog and sticky trap.
// Optional retired-instruction counter enabled by MIPS_MC_INSTR_COUNT_EN.
module mips_mc_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic           clk,
  input  logic           rst,
  mips_mc_ctrl_if.master bus
`ifdef MIPS_MC_INSTR_COUNT_EN
  ,
  output logic [CNT_WIDTH-1:0] instr_count
`endif
);

  ctrl_state_t r_state, w_state_nxt;
  trap_cause_t r_trap_cause, w_cause_nxt;
  logic        w_timeout;
  logic        w_retire;
  logic        w_unused_in;

  assign w_unused_in = ^{bus.funct, bus.alu_zero};

  mips_mem_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .clk        (clk),
    .rst        (rst),
    .i_req      (bus.mem_req),
    .i_ready    (bus.mem_ready),
    .o_timeout_c(w_timeout)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_FETCH;
      r_trap_cause <= CAUSE_NONE;
    end else begin
      r_state      <= w_state_nxt;
      r_trap_cause <= w_cause_nxt;
    end
  end

  // Moore decode of the state; fetch outputs are gated so reset drops mem_req at once.
  always_comb begin
    w_state_nxt       = r_state;
    w_cause_nxt       = r_trap_cause;
    w_retire          = 1'b0;
    bus.mem_req       = 1'b0;
    bus.mem_write     = 1'b0;
    bus.iord          = 1'b0;
    bus.ir_write      = 1'b0;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.pc_src        = PC_ALU;
    bus.reg_write_en  = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = SRCB_RT;
    bus.alu_op        = ALU_ADD;
    bus.trap          = 1'b0;
    bus.trap_cause    = r_trap_cause;

    case (r_state)
      ST_FETCH: begin
        if (rst) begin
          bus.mem_req   = 1'b1;
          bus.alu_src_b = SRCB_FOUR;
          if (bus.mem_ready) begin
            bus.ir_write = 1'b1;
            bus.pc_write = 1'b1;
            w_state_nxt  = ST_DECODE;
          end else if (w_timeout) begin
            w_state_nxt = ST_TRAP;
            w_cause_nxt = CAUSE_FETCH_TO;
          end
        end
      end
      ST_DECODE: begin
        bus.alu_src_b = SRCB_IMM_SH2;
        w_state_nxt   = decode_next(bus.opcode);
        if (w_state_nxt == ST_TRAP) w_cause_nxt = CAUSE_ILLEGAL;
      end
      ST_MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
        w_state_nxt   = (bus.opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      end
      ST_MEM_RD: begin
        bus.mem_req = 1'b1;
        bus.iord    = 1'b1;
        if (bus.mem_ready) begin
          w_state_nxt = ST_MEM_WB;
        end else if (w_timeout) begin
          w_state_nxt = ST_TRAP;
          w_cause_nxt = CAUSE_DATA_TO;
        end
      end
      ST_MEM_WB: begin
        bus.reg_write_en = 1'b1;
        bus.mem_to_reg   = 1'b1;
        w_retire         = 1'b1;
        w_state_nxt      = ST_FETCH;
      end
      ST_MEM_WR: begin
        bus.mem_req   = 1'b1;
        bus.iord      = 1'b1;
        bus.mem_write = 1'b1;
        if (bus.mem_ready) begin
          w_retire    = 1'b1;
          w_state_nxt = ST_FETCH;
        end else if (w_timeout) begin
          w_state_nxt = ST_TRAP;
          w_cause_nxt = CAUSE_DATA_TO;
        end
      end
      ST_R_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = ALU_FUNCT;
        w_state_nxt   = ST_R_WB;
      end
      ST_R_WB: begin
        bus.reg_write_en = 1'b1;
        bus.reg_dst      = 1'b1;
        w_retire         = 1'b1;
        w_state_nxt      = ST_FETCH;
      end
      ST_I_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
        w_state_nxt   = ST_I_WB;
      end
      ST_I_WB: begin
        bus.reg_write_en = 1'b1;
        w_retire         = 1'b1;
        w_state_nxt      = ST_FETCH;
      end
      ST_BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = ALU_SUB;
        bus.pc_write_cond = 1'b1;
        bus.pc_src        = PC_ALUOUT;
        w_retire          = 1'b1;
        w_state_nxt       = ST_FETCH;
      end
      ST_JUMP: begin
        bus.pc_write = 1'b1;
        bus.pc_src   = PC_JUMP;
        w_retire     = 1'b1;
        w_state_nxt  = ST_FETCH;
      end
      ST_TRAP: begin
        bus.trap = 1'b1;
      end
      default: begin
        w_state_nxt = ST_FETCH;
      end
    endcase
  end

`ifdef MIPS_MC_INSTR_COUNT_EN
  logic [CNT_WIDTH-1:0] r_instr_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_instr_count <= '0;
    end else if (w_retire) begin
      r_instr_count <= r_instr_count + CNT_WIDTH'(1);
    end
  end

  assign instr_count = r_instr_count;
`else
  localparam int unsigned CNT_WIDTH_UNUSED = CNT_WIDTH;
  logic w_unused_retire;
  assign w_unused_retire = w_retire;
`endif

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Scoreboard bench for mips_mc_ctrl: per-instruction cycle expectations from the class tables.
module tb_mips_mc_ctrl;
  import mips_pkg::*;

  localparam int unsigned TO = 4;
  localparam int unsigned CW = 4;

  localparam int PH_FETCH = 0, PH_DECODE = 1, PH_MADDR = 2, PH_MRD = 3, PH_MWB = 4,
                 PH_MWR = 5, PH_REX = 6, PH_RWB = 7, PH_IEX = 8, PH_IWB = 9,
                 PH_BR = 10, PH_J = 11, PH_TRAP = 12, PH_IDLE = 13;

  typedef struct packed {
    logic       mem_req, mem_write, iord, ir_write, pc_write, pc_write_cond;
    logic [1:0] pc_src;
    logic       reg_write_en, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, alu_op;
    logic       trap;
    logic [1:0] trap_cause;
  } outs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mips_mc_ctrl_if bus ();

`ifdef MIPS_MC_INSTR_COUNT_EN
  logic [CW-1:0] instr_count;
`endif

  mips_mc_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef MIPS_MC_INSTR_COUNT_EN
    ,
    .instr_count(instr_count)
`endif
  );

  outs_t      exp_q[$];
  int         cnt_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         n_cyc   = 0;
  int         model_cnt = 0;
  logic [5:0] cur_op = 6'h00;

  // Expected outputs of one cycle of a given instruction phase.
  function automatic outs_t ph(input int p, input logic rdy, input logic [1:0] cause);
    outs_t e = '0;
    case (p)
      PH_FETCH:  begin e.mem_req = 1; e.alu_src_b = 2'd1; e.ir_write = rdy; e.pc_write = rdy; end
      PH_DECODE: e.alu_src_b = 2'd3;
      PH_MADDR:  begin e.alu_src_a = 1; e.alu_src_b = 2'd2; end
      PH_MRD:    begin e.mem_req = 1; e.iord = 1; end
      PH_MWB:    begin e.reg_write_en = 1; e.mem_to_reg = 1; end
      PH_MWR:    begin e.mem_req = 1; e.iord = 1; e.mem_write = 1; end
      PH_REX:    begin e.alu_src_a = 1; e.alu_op = 2'd2; end
      PH_RWB:    begin e.reg_write_en = 1; e.reg_dst = 1; end
      PH_IEX:    begin e.alu_src_a = 1; e.alu_src_b = 2'd2; end
      PH_IWB:    e.reg_write_en = 1;
      PH_BR:     begin e.alu_src_a = 1; e.alu_op = 2'd1; e.pc_write_cond = 1; e.pc_src = 2'd1; end
      PH_J:      begin e.pc_write = 1; e.pc_src = 2'd2; end
      PH_TRAP:   begin e.trap = 1; e.trap_cause = cause; end
      default:   e = '0;
    endcase
    return e;
  endfunction

  function automatic outs_t sample();
    outs_t a;
    a.mem_req = bus.mem_req;             a.mem_write = bus.mem_write;
    a.iord = bus.iord;                   a.ir_write = bus.ir_write;
    a.pc_write = bus.pc_write;           a.pc_write_cond = bus.pc_write_cond;
    a.pc_src = 2'(bus.pc_src);           a.reg_write_en = bus.reg_write_en;
    a.reg_dst = bus.reg_dst;             a.mem_to_reg = bus.mem_to_reg;
    a.alu_src_a = bus.alu_src_a;         a.alu_src_b = 2'(bus.alu_src_b);
    a.alu_op = 2'(bus.alu_op);           a.trap = bus.trap;
    a.trap_cause = 2'(bus.trap_cause);
    return a;
  endfunction

  // One clock cycle of stimulus plus its expectation.
  task automatic cyc(input outs_t e, input logic rdy, input logic rv);
    @(posedge clk);
    #1;
    rst           = rv;
    bus.mem_ready = rdy;
    bus.opcode    = cur_op;
    bus.alu_zero  = 1'($urandom);
    bus.funct     = 6'($urandom);
    if (!rv) model_cnt = 0;
    exp_q.push_back(rv ? e : outs_t'(0));
    cnt_q.push_back(model_cnt);
  endtask

  task automatic idle(input logic rv);
    cyc(ph(PH_IDLE, 0, 0), 1'($urandom), rv);
  endtask

  // Memory access lasting waits+1 cycles, or trapping after TO unanswered cycles.
  task automatic mem_wait(input int p, input int waits, output logic ok);
    logic rdy;
    ok = 0;
    for (int i = 0; i < int'(TO); i++) begin
      rdy = (i == waits);
      cyc(ph(p, rdy, 0), rdy, 1'b1);
      if (rdy) begin
        ok = 1;
        return;
      end
    end
  endtask

  task automatic trap_and_reset(input logic [1:0] cause);
    for (int i = 0; i < 3; i++) cyc(ph(PH_TRAP, 0, cause), 1'($urandom), 1'b1);
    idle(1'b0);
    idle(1'b0);
  endtask

  task automatic run_instr(input logic [5:0] op, input int wf, input int wm);
    logic ok;
    cur_op = op;
    mem_wait(PH_FETCH, wf, ok);
    if (!ok) begin
      trap_and_reset(2'd2);
      return;
    end
    cyc(ph(PH_DECODE, 0, 0), 1'($urandom), 1'b1);
    case (op)
      OP_RTYPE: begin
        cyc(ph(PH_REX, 0, 0), 1'($urandom), 1'b1);
        cyc(ph(PH_RWB, 0, 0), 1'($urandom), 1'b1);
        model_cnt++;
      end
      OP_ADDI: begin
        cyc(ph(PH_IEX, 0, 0), 1'($urandom), 1'b1);
        cyc(ph(PH_IWB, 0, 0), 1'($urandom), 1'b1);
        model_cnt++;
      end
      OP_BEQ: begin
        cyc(ph(PH_BR, 0, 0), 1'($urandom), 1'b1);
        model_cnt++;
      end
      OP_J: begin
        cyc(ph(PH_J, 0, 0), 1'($urandom), 1'b1);
        model_cnt++;
      end
      OP_LW: begin
        cyc(ph(PH_MADDR, 0, 0), 1'($urandom), 1'b1);
        mem_wait(PH_MRD, wm, ok);
        if (!ok) begin
          trap_and_reset(2'd3);
        end else begin
          cyc(ph(PH_MWB, 0, 0), 1'($urandom), 1'b1);
          model_cnt++;
        end
      end
      OP_SW: begin
        cyc(ph(PH_MADDR, 0, 0), 1'($urandom), 1'b1);
        mem_wait(PH_MWR, wm, ok);
        if (!ok) trap_and_reset(2'd3);
        else     model_cnt++;
      end
      default: trap_and_reset(2'd1);
    endcase
  endtask

  function automatic int pick_wait();
    return ($urandom_range(0, 9) == 0) ? int'(TO) : int'($urandom_range(0, 2));
  endfunction

  // Monitor: one expectation per cycle, compared mid-cycle.
  initial begin
    outs_t e, a;
    int    c;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        c = cnt_q.pop_front();
        a = sample();
        n_cyc++;
        n_tests++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL outputs cycle=%0d got=%b exp=%b", n_cyc, a, e);
        end
`ifdef MIPS_MC_INSTR_COUNT_EN
        n_tests++;
        if (instr_count !== CW'(c)) begin
          n_fail++;
          $display("FAIL instr_count cycle=%0d got=%0d exp=%0d", n_cyc, instr_count, CW'(c));
        end
`endif
      end
    end
  end

  initial begin
    logic [5:0] ops [7];
    ops[0] = OP_RTYPE; ops[1] = OP_LW; ops[2] = OP_SW; ops[3] = OP_BEQ;
    ops[4] = OP_ADDI;  ops[5] = OP_J;  ops[6] = 6'h3F;
    bus.opcode = 6'h00; bus.funct = 6'h00; bus.alu_zero = 1'b0; bus.mem_ready = 1'b0;

    idle(1'b0);
    idle(1'b0);
    run_instr(OP_RTYPE, 0, 0);
    run_instr(OP_SW, 0, 0);
    run_instr(OP_LW, 0, 0);
    run_instr(OP_BEQ, 0, 0);
    run_instr(OP_BEQ, 0, 0);
    run_instr(OP_J, 0, 0);
    run_instr(OP_ADDI, 3, 0);
    run_instr(OP_LW, 1, 3);
    for (int i = 0; i < 17; i++) run_instr(OP_ADDI, 0, 0);
    run_instr(OP_LW, 0, 100);
    run_instr(6'h3F, 0, 0);
    run_instr(OP_ADDI, 100, 0);
    run_instr(OP_SW, 2, int'(TO));

    // Reset asserted while a fetch is waiting abandons the request.
    cur_op = OP_ADDI;
    cyc(ph(PH_FETCH, 0, 0), 1'b0, 1'b1);
    cyc(ph(PH_FETCH, 0, 0), 1'b0, 1'b1);
    cyc(ph(PH_IDLE, 0, 0), 1'b1, 1'b0);
    idle(1'b0);
    run_instr(OP_RTYPE, 0, 0);

    for (int i = 0; i < 120; i++) begin
      run_instr(ops[$urandom_range(0, 6)], pick_wait(), pick_wait());
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
- Multi-cycle control unit for the MIPS processor. It sequences PC, instruction register, register file, ALU and a shared unified memory port through fetch/decode/execute/memory/writeback states.
- Opcode and funct come from the instruction register. All datapath enables are Moore outputs of this FSM.
- Memory accesses use a req/ready handshake. A watchdog traps hung accesses.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles mem_req may wait for mem_ready before trapping; 1..65535.
- CNT_WIDTH, 32, width of the retired-instruction counter (optional feature only).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- opcode  input  6  instr[31:26] from IR.
- funct  input  6  instr[5:0] from IR.
- alu_zero  input  1  ALU zero flag.
- mem_ready  input  1  memory completes the current access this cycle.
- mem_req  output  1  memory access request.
- mem_write  output  1  1 = write, 0 = read; valid with mem_req.
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write  output  1  load IR from memory read data.
- pc_write  output  1  unconditional PC load.
- pc_write_cond  output  1  PC load if alu_zero.
- pc_src  output  2  0 = ALU result, 1 = ALUOut, 2 = jump target.
- reg_write_en  output  1  register file write.
- reg_dst  output  1  0 = rt, 1 = rd.
- mem_to_reg  output  1  0 = ALUOut, 1 = MDR.
- alu_src_a  output  1  0 = PC, 1 = rs.
- alu_src_b  output  2  0 = rt, 1 = const 4, 2 = sign-extended imm, 3 = sign-extended imm<<2.
- alu_op  output  2  0 = add, 1 = sub, 2 = funct-decode.
- trap  output  1  sticky: illegal opcode or memory timeout.
- trap_cause  output  2  0 = none, 1 = illegal opcode, 2 = fetch timeout, 3 = data timeout.

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = FETCH; watchdog = 0; trap = 0; trap_cause = 0.
  - All outputs deasserted except the FETCH Moore outputs, which become valid once rst = 1.
- FETCH:
  - Outputs: mem_req = 1, mem_write = 0, iord = 0, alu_src_a = 0, alu_src_b = 1, alu_op = 0, pc_src = 0.
  - ir_write and pc_write assert only in the cycle mem_ready = 1; that cycle goes to DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - Outputs: alu_src_a = 0, alu_src_b = 3, alu_op = 0 (branch target computed into ALUOut).
  - Next state by opcode:
    - 0x23 or 0x2B -> MEM_ADDR.
    - 0x00 -> R_EXEC.
    - 0x04 -> BRANCH.
    - 0x08 -> I_EXEC.
    - 0x02 -> JUMP.
    - anything else -> TRAP with cause 1.
  - funct is not checked here; the ALU decoder handles it.
- MEM_ADDR: alu_src_a = 1, alu_src_b = 2, alu_op = 0. Next: MEM_RD if opcode = 0x23, else MEM_WR.
- MEM_RD: mem_req = 1, iord = 1, mem_write = 0. Hold until mem_ready, then MEM_WB.
- MEM_WB: reg_write_en = 1, reg_dst = 0, mem_to_reg = 1. Next: FETCH.
- MEM_WR: mem_req = 1, iord = 1, mem_write = 1. Hold until mem_ready, then FETCH.
- R_EXEC: alu_src_a = 1, alu_src_b = 0, alu_op = 2. Next: R_WB.
- R_WB: reg_write_en = 1, reg_dst = 1, mem_to_reg = 0. Next: FETCH.
- I_EXEC: alu_src_a = 1, alu_src_b = 2, alu_op = 0. Next: I_WB.
- I_WB: reg_write_en = 1, reg_dst = 0, mem_to_reg = 0. Next: FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 0, alu_op = 1, pc_write_cond = 1, pc_src = 1. Next: FETCH.
- JUMP: pc_write = 1, pc_src = 2. Next: FETCH.
- TRAP:
  - Absorbing state; only reset exits.
  - All enables and mem_req are 0; trap = 1.
  - trap_cause is latched on entry.
- Latency in cycles, with zero memory wait: R-type 4, addi 4, lw 5, sw 4, beq 3, j 3. Each memory wait cycle adds 1.
- Handshake:
  - mem_req, mem_write and iord are stable from first assertion until the mem_ready cycle.
  - mem_ready while mem_req = 0 is ignored.
  - mem_ready in the first req cycle completes that cycle.
- Watchdog:
  - Counts cycles with mem_req = 1 && mem_ready = 0; cleared on any non-waiting cycle.
  - When the count reaches TIMEOUT_CYCLES with mem_ready still 0, the next state is TRAP.
  - Cause is 2 if the state is FETCH, 3 otherwise.
  - mem_ready arriving in that same cycle wins; no trap.
- Reset mid-access: mem_req drops asynchronously; the memory side must tolerate an abandoned request.

Optional Feature:
- Macro: MIPS_MC_INSTR_COUNT_EN.
- With the macro defined:
  - Extra output instr_count [CNT_WIDTH-1:0], reset to 0.
  - Increments by 1 on each retire edge: leaving MEM_WB, MEM_WR (on mem_ready), R_WB, I_WB, BRANCH or JUMP.
  - Wraps modulo 2^CNT_WIDTH; frozen in TRAP.
- Without the macro: the port and the counter logic are absent.

Decomposition:
- Package mips_pkg holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J;
  - enum ctrl_state_t;
  - enums alu_op_t, alu_src_b_t, pc_src_t, trap_cause_t.
- Sub-module mips_mem_watchdog: counter plus timeout compare, with inputs req/ready and output timeout.

Test Plan:
- add, then sw, then lw, then beq, all with mem_ready tied 1 -> state sequences of length 4/4/5/3. reg_write_en pulses in the R_WB and MEM_WB cycles only; mem_write = 1 only in the MEM_WR cycle.
- beq with alu_zero = 1 in BRANCH, then again with 0 -> pc_write_cond = 1 and pc_src = 1 in that cycle both times. The next state is FETCH both times.
- Fetch with mem_ready held low for 3 cycles -> mem_req = 1 and iord = 0 held stable for 4 cycles. ir_write pulses once, in the 4th cycle.
- TIMEOUT_CYCLES = 4, mem_ready never asserted during lw MEM_RD -> TRAP after 4 wait cycles with trap_cause = 3. All enables 0 until rst = 0.
- opcode 0x3F at DECODE -> TRAP with trap_cause = 1 and mem_req = 0. Asserting rst low returns to FETCH with trap = 0.
- MIPS_MC_INSTR_COUNT_EN defined, CNT_WIDTH = 4, run 17 addi instructions -> instr_count = 1, having wrapped after 15.
